// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack access with lane alignment and load extension.
// Feeds the MEM/WB register and holds the front of the pipe while busy.
module mem_stage #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ctrl_reg_write_EX,
  input  logic [1:0]  ctrl_wb_reg_src_EX,
  input  logic        ctrl_mem_r_EX,
  input  logic        ctrl_mem_w_EX,
  input  logic [2:0]  funct3_EX,
  input  logic [31:0] alu_out_EX,
  input  logic [31:0] rd2_EX,
  input  logic [31:0] pc_4_EX,
  input  logic [4:0]  reg_wb_addr_EX,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic        stall_MEM,
  output logic        ctrl_reg_write_MEM,
  output logic [4:0]  reg_wb_addr_MEM,
  output logic [31:0] reg_wb_data,
  output logic        fault_MEM
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic        r_req, r_we, r_to, r_wen, r_fault;
  logic [31:0] r_addr, r_wdata, r_rdata, r_wbd;
  logic [3:0]  r_be;
  logic [4:0]  r_wba;

  logic        w_access, w_ld_ok, w_st_ok, w_bad;
  logic        w_half, w_word, w_to_hit, w_stall;
  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_load, w_wbd;
  logic [15:0] w_hd;
  logic [7:0]  w_bd;

  assign w_a      = alu_out_EX[1:0];
  assign w_access = ctrl_mem_r_EX | ctrl_mem_w_EX;
  assign w_half   = funct3_EX[1:0] == 2'b01;
  assign w_word   = funct3_EX[1:0] == 2'b10;
  assign w_ld_ok  = (funct3_EX != 3'b011) && (funct3_EX[2:1] != 2'b11);
  assign w_st_ok  = !funct3_EX[2] && (funct3_EX[1:0] != 2'b11);

  assign w_bad = w_access &&
    ((ctrl_mem_r_EX && !w_ld_ok) ||
     (ctrl_mem_w_EX && !w_st_ok) ||
     (w_half && w_a[0]) ||
     (w_word && (w_a != 2'b00)));

  assign w_to_hit = (ACK_TIMEOUT != 0) &&
    (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Reset drops the stall at once even if EX still presents an access.
  assign w_stall = rstn &&
    (((r_state == S_IDLE) && w_access && !w_bad) ||
     (r_state == S_WAIT));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rd2_EX;
    if (ctrl_mem_w_EX) begin
      unique case (1'b1)
        w_word: begin
          w_be    = 4'b1111;
          w_wdata = rd2_EX;
        end
        w_half: begin
          w_be    = w_a[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{rd2_EX[15:0]}};
        end
        default: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{rd2_EX[7:0]}};
        end
      endcase
    end
  end

  assign w_shift = r_rdata >> {w_a, 3'b000};
  assign w_bd    = w_shift[7:0];
  assign w_hd    = w_a[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    unique case (funct3_EX)
      3'b000:  w_load = {{24{w_bd[7]}}, w_bd};
      3'b001:  w_load = {{16{w_hd[15]}}, w_hd};
      3'b100:  w_load = {24'd0, w_bd};
      3'b101:  w_load = {16'd0, w_hd};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    unique case (ctrl_wb_reg_src_EX)
      2'b01:   w_wbd = w_load;
      2'b10:   w_wbd = pc_4_EX;
      default: w_wbd = alu_out_EX;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_access && !w_bad) w_next = S_WAIT;
      S_WAIT: if (dm_ack || w_to_hit) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_to    <= 1'b0;
      r_wen   <= 1'b0;
      r_wba   <= '0;
      r_wbd   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_access && !w_bad) begin
            r_req   <= 1'b1;
            r_we    <= ctrl_mem_w_EX;
            r_addr  <= {alu_out_EX[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (dm_ack) begin
            r_rdata <= dm_rdata;
            r_req   <= 1'b0;
          end else if (w_to_hit) begin
            r_req <= 1'b0;
            r_to  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_to <= 1'b0;
      endcase
      if (!w_stall) begin
        r_wba   <= reg_wb_addr_EX;
        r_wbd   <= w_wbd;
        r_wen   <= ctrl_reg_write_EX && !w_bad &&
                   !((r_state == S_DONE) && r_to);
        r_fault <= ((r_state == S_IDLE) && w_bad) ||
                   ((r_state == S_DONE) && r_to);
      end
    end
  end

  assign dm_req             = r_req;
  assign dm_we              = r_we;
  assign dm_addr            = r_addr;
  assign dm_be              = r_be;
  assign dm_wdata           = r_wdata;
  assign stall_MEM          = w_stall;
  assign ctrl_reg_write_MEM = r_wen;
  assign reg_wb_addr_MEM    = r_wba;
  assign reg_wb_data        = r_wbd;
  assign fault_MEM          = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, faults, timeout, async reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rw;
  logic [1:0]  src;
  logic        mr, mw;
  logic [2:0]  f3;
  logic [31:0] alu, rd2, pc4;
  logic [4:0]  rd;
  logic        ack;
  logic [31:0] rdata;
  logic        req, we, stall, wen, fault;
  logic [31:0] addr, wdata, wbd;
  logic [3:0]  be;
  logic [4:0]  wba;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .ctrl_reg_write_EX(rw), .ctrl_wb_reg_src_EX(src),
    .ctrl_mem_r_EX(mr), .ctrl_mem_w_EX(mw),
    .funct3_EX(f3), .alu_out_EX(alu), .rd2_EX(rd2),
    .pc_4_EX(pc4), .reg_wb_addr_EX(rd),
    .dm_ack(ack), .dm_rdata(rdata),
    .dm_req(req), .dm_we(we), .dm_addr(addr),
    .dm_be(be), .dm_wdata(wdata), .stall_MEM(stall),
    .ctrl_reg_write_MEM(wen), .reg_wb_addr_MEM(wba),
    .reg_wb_data(wbd), .fault_MEM(fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic i_rw, input logic [1:0] i_src,
                        input logic i_r, input logic i_w,
                        input logic [2:0] i_f3, input logic [31:0] i_alu,
                        input logic [31:0] i_rd2, input logic [31:0] i_pc4,
                        input logic [4:0] i_rd);
    rw = i_rw; src = i_src; mr = i_r; mw = i_w; f3 = i_f3;
    alu = i_alu; rd2 = i_rd2; pc4 = i_pc4; rd = i_rd;
  endtask

  // Ack with given data on the first WAIT cycle, then step through DONE.
  task automatic ack1(input logic [31:0] d);
    step();
    ack = 1'b1; rdata = d;
    step();
    ack = 1'b0;
    step();
  endtask

  initial begin
    rstn = 1'b0; ack = 1'b0; rdata = '0;
    set_op(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
    #1;
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wen", wen, 0);
    chk("rst_wbd", wbd, 0);
    chk("rst_fault", fault, 0);
    #11 rstn = 1'b1;
    step();

    set_op(1, 2'b00, 0, 0, 3'b000, 32'h1234, 0, 0, 5);
    #1 chk("alu_stall", stall, 0);
    step();
    chk("alu_wbd", wbd, 32'h1234);
    chk("alu_wen", wen, 1);
    chk("alu_wba", wba, 5);
    chk("alu_stall2", stall, 0);

    set_op(1, 2'b01, 1, 0, 3'b000, 32'h103, 0, 32'h44, 7);
    #1 chk("lb_stall0", stall, 1);
    step();
    chk("lb_req", req, 1);
    chk("lb_addr", addr, 32'h100);
    chk("lb_be", be, 4'hF);
    chk("lb_we", we, 0);
    chk("lb_stall1", stall, 1);
    chk("lb_hold", wbd, 32'h1234);
    ack = 1'b1; rdata = 32'h80FF_0000;
    step();
    ack = 1'b0;
    chk("lb_req_done", req, 0);
    chk("lb_stall_done", stall, 0);
    step();
    chk("lb_wbd", wbd, 32'hFFFF_FF80);
    chk("lb_wen", wen, 1);
    chk("lb_wba", wba, 7);

    set_op(1, 2'b01, 1, 0, 3'b100, 32'h103, 0, 0, 7);
    ack1(32'h80FF_0000);
    chk("lbu_wbd", wbd, 32'h0000_0080);

    set_op(1, 2'b01, 1, 0, 3'b001, 32'h102, 0, 0, 8);
    ack1(32'h80FF_0000);
    chk("lh_wbd", wbd, 32'hFFFF_80FF);

    set_op(1, 2'b01, 1, 0, 3'b101, 32'h100, 0, 0, 8);
    ack1(32'h1234_8001);
    chk("lhu_wbd", wbd, 32'h0000_8001);

    set_op(1, 2'b10, 1, 0, 3'b010, 32'h104, 0, 32'h88, 9);
    step();
    step();
    chk("lw_wait2_stall", stall, 1);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    ack = 1'b0;
    step();
    chk("lw_pc4_wbd", wbd, 32'h88);

    set_op(1, 2'b01, 1, 0, 3'b010, 32'h104, 0, 0, 9);
    ack1(32'hDEAD_BEEF);
    chk("lw_wbd", wbd, 32'hDEAD_BEEF);

    set_op(0, 2'b00, 0, 1, 3'b001, 32'h202, 32'hABCD_1234, 0, 0);
    step();
    chk("sh_req", req, 1);
    chk("sh_we", we, 1);
    chk("sh_addr", addr, 32'h200);
    chk("sh_be", be, 4'b1100);
    chk("sh_wdata", wdata, 32'h1234_1234);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("sh_fault", fault, 0);
    chk("sh_wen", wen, 0);

    set_op(0, 2'b00, 0, 1, 3'b000, 32'h301, 32'h0000_0055, 0, 0);
    step();
    chk("sb_be", be, 4'b0010);
    chk("sb_wdata", wdata, 32'h5555_5555);
    chk("sb_addr", addr, 32'h300);
    ack1(32'h0);

    set_op(1, 2'b01, 1, 0, 3'b010, 32'h101, 0, 0, 9);
    #1 chk("mis_stall", stall, 0);
    step();
    chk("mis_fault", fault, 1);
    chk("mis_req", req, 0);
    chk("mis_wen", wen, 0);
    set_op(1, 2'b00, 0, 0, 3'b000, 32'h77, 0, 0, 3);
    step();
    chk("mis_next_fault", fault, 0);
    chk("mis_next_wbd", wbd, 32'h77);

    set_op(0, 2'b00, 0, 1, 3'b011, 32'h100, 0, 0, 0);
    #1 chk("ill_stall", stall, 0);
    step();
    chk("ill_fault", fault, 1);
    chk("ill_req", req, 0);

    set_op(1, 2'b01, 1, 0, 3'b010, 32'h100, 0, 0, 4);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), req, 1);
      step();
    end
    chk("to_req_drop", req, 0);
    chk("to_stall_done", stall, 0);
    step();
    chk("to_fault", fault, 1);
    chk("to_wen", wen, 0);
    set_op(1, 2'b00, 0, 0, 3'b000, 32'h99, 0, 0, 6);
    step();
    chk("to_next_wbd", wbd, 32'h99);
    chk("to_next_wen", wen, 1);
    chk("to_next_fault", fault, 0);

    set_op(1, 2'b01, 1, 0, 3'b010, 32'h108, 0, 0, 8);
    step();
    step();
    #2 rstn = 1'b0;
    #1;
    chk("ar_req", req, 0);
    chk("ar_stall", stall, 0);
    chk("ar_wen", wen, 0);
    chk("ar_wbd", wbd, 0);
    chk("ar_wba", wba, 0);
    chk("ar_addr", addr, 0);
    chk("ar_be", be, 0);
    set_op(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    ack = 1'b1; rdata = 32'hCAFE_F00D;
    step();
    ack = 1'b0;
    chk("late_req", req, 0);
    chk("late_stall", stall, 0);
    chk("late_wbd", wbd, 0);
    set_op(1, 2'b00, 0, 0, 3'b000, 32'hAB, 0, 0, 2);
    #1 chk("post_stall", stall, 0);
    step();
    chk("post_wbd", wbd, 32'hAB);
    chk("post_wen", wen, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly downstream of EX.
- Consumes the EX/MEM pipeline register and runs loads/stores over a req/ack data-memory port with byte-lane alignment and load sign/zero extension.
- Drives the MEM/WB register: `ctrl_reg_write_MEM`, `reg_wb_addr_MEM` and `reg_wb_data` go to WB and to EX forwarding.
- Raises `stall_MEM` while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 255: max WAIT cycles before abort; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy ACK_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ctrl_reg_write_EX  in  1  instruction writes rd
- ctrl_wb_reg_src_EX  in  2  00 alu, 01 load data, 10 pc+4, 11 treated as alu
- ctrl_mem_r_EX  in  1  load
- ctrl_mem_w_EX  in  1  store
- funct3_EX  in  3  access size/sign
- alu_out_EX  in  32  effective address / alu result
- rd2_EX  in  32  store data
- pc_4_EX  in  32  link value
- reg_wb_addr_EX  in  5  rd
- dm_ack  in  1  memory done, 1-cycle pulse
- dm_rdata  in  32  read word, valid with dm_ack
- dm_req  out  1  request, registered
- dm_we  out  1  1 = store
- dm_addr  out  32  word address, {alu_out_EX[31:2],2'b00}
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- stall_MEM  out  1  hold EX/ID/IF
- ctrl_reg_write_MEM  out  1  MEM/WB write enable
- reg_wb_addr_MEM  out  5  MEM/WB rd
- reg_wb_data  out  32  MEM/WB data
- fault_MEM  out  1  1-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (async, rstn=0): state=IDLE, counter=0, every output 0; an access in flight is abandoned.
- `access = ctrl_mem_r_EX | ctrl_mem_w_EX`.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - anything else is illegal.
- `bad` is set for an illegal funct3, or a half access with addr[0]=1, or a word access with addr[1:0]≠0.
- State IDLE:
  - !access, or access with bad: stall_MEM=0. MEM/WB updates at the edge.
  - When bad, ctrl_reg_write_MEM<=0 and fault_MEM<=1, and no bus cycle is issued.
  - access with !bad: stall_MEM=1 combinationally. At the edge: dm_req<=1, dm_we/dm_addr/dm_be/dm_wdata latched, counter<=0, state<=WAIT.
- State WAIT:
  - stall_MEM=1 and bus outputs held stable.
  - dm_ack=1: capture dm_rdata, dm_req<=0, state<=DONE.
  - Else, if ACK_TIMEOUT≠0 and counter==ACK_TIMEOUT-1: dm_req<=0, flag timeout, state<=DONE.
  - Else counter<=counter+1.
- State DONE:
  - stall_MEM=0 and dm_req=0. MEM/WB updates at the edge; state<=IDLE.
  - After a timeout, ctrl_reg_write_MEM<=0 and fault_MEM<=1.
- dm_ack outside WAIT is ignored.
- MEM/WB register:
  - Updates only when stall_MEM=0; it holds during stall, so forwarding stays valid.
  - `reg_wb_data` is selected by src: 00 or 11 → alu_out_EX, 01 → load data, 10 → pc_4_EX.
  - fault_MEM is 0 on every non-fault update.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{rd2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rd2[15:0]}}.
  - SW: be = 1111, wdata = rd2.
- Loads:
  - dm_be=1111.
  - Byte select = rdata >> (8*addr[1:0]); half select = addr[1] ? rdata[31:16] : rdata[15:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- Latency: a memory op takes 3 cycles minimum (IDLE, WAIT with ack, DONE), so stall_MEM is high for 1+N cycles for an ack in the N-th WAIT cycle. Non-memory ops take 1 cycle with no stall.
- Back-to-back accesses: DONE→IDLE, then the next access starts in IDLE. dm_req is low for at least 1 cycle between requests.

Test Plan:
- ALU op: src=00, alu_out=0x1234, rd=5 → next edge reg_wb_data=0x1234, ctrl_reg_write_MEM=1, reg_wb_addr_MEM=5, stall_MEM never high.
- LB at alu_out=0x103, ack on the 1st WAIT cycle, rdata=0x80FF_0000:
  - dm_addr=0x100, be=1111, stall_MEM high 2 cycles.
  - reg_wb_data=0xFFFF_FF80.
  - Repeating as LBU gives 0x0000_0080.
- SH at 0x202, rd2=0xABCD_1234 → dm_we=1, dm_addr=0x200, be=1100, dm_wdata=0x1234_1234.
- LW at 0x101 → fault_MEM pulse, dm_req stays 0, ctrl_reg_write_MEM=0, no stall.
- ACK_TIMEOUT=4, dm_ack never asserted:
  - dm_req drops after 4 WAIT cycles, then fault_MEM=1 and ctrl_reg_write_MEM=0.
  - A subsequent ALU op completes normally.
- LW with ack delayed 3 cycles; rstn pulsed low in the 2nd WAIT cycle → immediately dm_req=0, stall_MEM=0, all outputs 0; a late dm_ack is ignored and state is IDLE.
